// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-priority or round-robin
// arbitration, zero/multi-hot flags and a valid/ready output stage.
module prio_encoder_rr #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_zero,
    output logic         out_multi,
    output logic         out_valid,
    input  logic         out_ready
);

    // Highest set index wins; later loop iterations override earlier ones.
    function automatic logic [W-1:0] fixed_winner(input logic [N-1:0] r);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            w = r[i] ? W'(i) : w;
        end
        return w;
    endfunction

    // Walk offsets from far to near so the set bit closest to ptr (with wrap at N) wins.
    function automatic logic [W-1:0] rr_winner(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] w;
        logic [W-1:0] j_idx;
        int           j;
        w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j     = int'(p) + k;
            j     = (j >= N) ? (j - N) : j;
            j_idx = W'(j);
            w     = r[j_idx] ? j_idx : w;
        end
        return w;
    endfunction

    function automatic logic is_multi_hot(input logic [N-1:0] r);
        return ((r & (r - N'(1))) != '0);
    endfunction

    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         zero_q, zero_d;
    logic         multi_q, multi_d;
    logic         valid_q, valid_d;

    logic         accept_s;
    logic         xfer_s;
    logic         req_zero_s;
    logic [W-1:0] win_s;

    assign in_ready   = !valid_q | out_ready;
    assign accept_s   = in_valid & in_ready;
    assign xfer_s     = valid_q & out_ready;
    assign req_zero_s = (req == '0);

    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_zero   = zero_q;
    assign out_multi  = multi_q;
    assign out_valid  = valid_q;

    // Winner selection and next-state for the pointer and output register.
    always_comb begin
        win_s    = '0;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        zero_d   = zero_q;
        multi_d  = multi_q;
        valid_d  = valid_q;

        if (req_zero_s) begin
            win_s = '0;
        end else if (mode) begin
            win_s = rr_winner(req, ptr_q);
        end else begin
            win_s = fixed_winner(req);
        end

        if (accept_s) begin
            idx_d    = win_s;
            onehot_d = req_zero_s ? '0 : (N'(1) << win_s);
            zero_d   = req_zero_s;
            multi_d  = is_multi_hot(req);
            valid_d  = 1'b1;
            // Pointer advances past the winner at accept time; all-zero vectors leave it alone.
            if (mode && !req_zero_s) begin
                ptr_d = (win_s == W'(N - 1)) ? '0 : (win_s + W'(1));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register and round-robin pointer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            zero_q   <= 1'b0;
            multi_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            zero_q   <= zero_d;
            multi_q  <= multi_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) encoder; successor to the combinational 8:3 one-hot encoder.
- Accepts non-one-hot inputs and resolves them by fixed-priority or round-robin selection.
- Flags all-zero and multi-hot vectors.
- Registers the result behind a valid/ready output handshake so it can sit between pipelined request sources and downstream grant/decode logic.

Parameters:
- N, 8, number of request lines; integer ≥ 2, power of two not required.
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, sampled on input handshake.
- in_valid  input  1  req is valid this cycle.
- in_ready  output  1  block can accept req this cycle.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin; sampled with req.
- out_idx  output  W  encoded winning index.
- out_onehot  output  N  one-hot of winner; all zero when out_zero=1.
- out_zero  output  1  captured req was all zero.
- out_multi  output  1  captured req had ≥2 bits set.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_idx=0, out_onehot=0, out_zero=0, out_multi=0, RR pointer ptr=0. in_ready follows its equation, so it is 1 during reset.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: 1 cycle. A vector accepted at edge k appears on the outputs after edge k with out_valid=1.
- Hold: while out_valid & !out_ready, all out_* are stable. in_ready=0, so req is ignored.
- Output register update:
  - Simultaneous transfer and accept: load the new result, out_valid stays 1 (back-to-back throughput of 1/cycle).
  - Transfer with no accept: out_valid falls to 0. Data outputs keep their last value.
- Fixed priority (mode=0): winner = highest set index; for one-hot req this equals the plain binary encode. ptr is not modified.
- Round-robin (mode=1):
  - Search starts at ptr, increasing index with wrap N-1 → 0. First set bit wins.
  - On accepting a nonzero vector, ptr <= (winner+1) mod N; when winner = N-1, ptr wraps to 0.
  - ptr update happens at the accept edge, not at the output transfer.
- All-zero req: out_zero=1, out_idx=0, out_onehot=0, out_multi=0, out_valid=1 (result still delivered). ptr is unchanged in either mode.
- Flags: out_multi=1 iff popcount(captured req) ≥ 2. out_zero and out_multi are never both 1.
- Mode switch: takes effect per accepted vector. ptr keeps its value across mode changes and is only cleared by reset.
- Reset mid-operation: any pending result is discarded immediately, ptr=0. The first accept after rst_n rises behaves as from power-up.
- N not a power of two: out_idx never exceeds N-1, and ptr wrap uses N, not 2^W.

Test Plan:
- Fixed priority, N=8: apply one-hot req from 8'h01 to 8'h80, mode=0, out_ready=1, one per cycle → out_idx 0..7, each 1 cycle after accept. out_multi=0, out_zero=0, throughput 1/cycle.
- Fixed priority, multi-hot: req=8'b0010_1100, mode=0 → out_idx=5, out_onehot=8'h20, out_multi=1. req=8'h00 → out_zero=1, out_idx=0, out_onehot=0.
- Round-robin rotation: after reset, mode=1, req=8'hFF held for 10 accepts → out_idx 0,1,...,7,0,1. Then req=8'b1000_0001 with ptr=2 → idx 7, then 0, then 7.
- Backpressure: out_ready=0 after first result (req=8'h10, mode=0) → in_ready=0, out_idx=4 stable for 5 cycles while req changes to 8'h02. Raise out_ready → transfer occurs and in_ready=1 the same cycle; idx 1 appears next cycle.
- Reset mid-stream: mode=1 with ptr=5 and out_valid=1 → assert rst_n=0 asynchronously between edges. All outputs clear at once and out_valid=0. After release, req=8'hFF → out_idx=0.
- N=5 instance (W=3): mode=1, req=5'b11111, 7 accepts → 0,1,2,3,4,0,1, with out_idx never ≥5.
